// File: rtl/usb_pkg.sv
// Shared USB line-level constants, packet length defaults and TX state encoding.
package usb_pkg;

  localparam int unsigned CNT_W = 7;

  localparam int unsigned DATA_BITS_DEF   = 88;
  localparam int unsigned HSHAKE_BITS_DEF = 8;

  // Line symbols as {dp, dm}
  localparam logic [1:0] SYM_J = 2'b10;
  localparam logic [1:0] SYM_K = 2'b01;
  localparam logic [1:0] SYM_X = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_DATA = 3'd2,
    ST_EOP1 = 3'd3,
    ST_EOP2 = 3'd4,
    ST_EOPJ = 3'd5
  } tx_state_e;

  // SYNC pattern K,J,K,J,K,J,K,K: J on odd positions except the final slot
  function automatic logic [1:0] sync_sym(input logic [2:0] idx);
    return (idx[0] && (idx != 3'd7)) ? SYM_J : SYM_K;
  endfunction

endpackage

// File: rtl/tx_dpdm_cnt.sv
// Generic 7-bit up counter with synchronous clear (clear wins over increment).
module tx_dpdm_cnt
  import usb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_q
);

  logic [CNT_W-1:0] cnt_d;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_dpdm.sv
// USB packet line driver: SYNC, NRZI payload from tx_nrzi, then SE0,SE0,J EOP.
module tx_dpdm
  import usb_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_DEF,
  parameter int unsigned HSHAKE_BITS = HSHAKE_BITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_data,
  input  logic       send_hshake,
  input  logic       abort,
  input  logic       s_in,
  output logic       start_tx_nrzi,
  output logic       bit_take,
  output logic       end_tx_nrzi,
  output logic [1:0] bus_out,
  output logic       bus_en,
  output logic       busy,
  output logic       done
);

  localparam logic [CNT_W-1:0] DATA_LEN   = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] HSHAKE_LEN = CNT_W'(HSHAKE_BITS);
  localparam logic [CNT_W-1:0] SYNC_LAST  = CNT_W'(7);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] len_last;
  logic             cnt_clr, cnt_inc;

  assign len_last = len_q - CNT_W'(1);

  // Shared bit/symbol counter
  tx_dpdm_cnt u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt_q (cnt_q)
  );

  // Next state, length latch and Moore outputs; abort overrides everything
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    cnt_clr       = 1'b0;
    cnt_inc       = 1'b0;
    start_tx_nrzi = 1'b0;
    bit_take      = 1'b0;
    end_tx_nrzi   = 1'b0;
    bus_out       = SYM_X;
    bus_en        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (send_hshake) begin
          len_d   = HSHAKE_LEN;
          cnt_clr = 1'b1;
          state_d = ST_SYNC;
        end else if (send_data) begin
          len_d   = DATA_LEN;
          cnt_clr = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        bus_en  = 1'b1;
        busy    = 1'b1;
        bus_out = sync_sym(cnt_q[2:0]);
        cnt_inc = 1'b1;
        if (cnt_q == SYNC_LAST) begin
          start_tx_nrzi = 1'b1;
          cnt_clr       = 1'b1;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        bus_en   = 1'b1;
        busy     = 1'b1;
        bit_take = 1'b1;
        bus_out  = s_in ? SYM_J : SYM_K;
        cnt_inc  = 1'b1;
        if (cnt_q == len_last) begin
          end_tx_nrzi = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ST_EOP1;
        end
      end
      ST_EOP1: begin
        bus_en  = 1'b1;
        busy    = 1'b1;
        state_d = ST_EOP2;
      end
      ST_EOP2: begin
        bus_en  = 1'b1;
        busy    = 1'b1;
        state_d = ST_EOPJ;
      end
      ST_EOPJ: begin
        bus_en  = 1'b1;
        busy    = 1'b1;
        bus_out = SYM_J;
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    if (abort) begin
      state_d     = ST_IDLE;
      len_d       = len_q;
      cnt_clr     = 1'b1;
      cnt_inc     = 1'b0;
      done        = 1'b0;
      end_tx_nrzi = 1'b0;
    end
  end

  // State and latched length registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= DATA_LEN;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: doc/tx_dpdm.md
TX_DPDM -- requirements
Module: tx_dpdm

Interface
REQ-001 SHALL have parameter DATA_BITS, default 88, meaning payload bit count for a data packet.
REQ-002 SHALL have parameter HSHAKE_BITS, default 8, meaning payload bit count for a handshake packet.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port send_data  input  1  protocol FSM requests a DATA_BITS packet.
REQ-006 SHALL have port send_hshake  input  1  protocol FSM requests a HSHAKE_BITS packet.
REQ-007 SHALL have port abort  input  1  synchronous abort; returns the block to IDLE.
REQ-008 SHALL have port s_in  input  1  current NRZI bit from tx_nrzi.
REQ-009 SHALL have port start_tx_nrzi  output  1  pulse: tx_nrzi presents its first bit next cycle.
REQ-010 SHALL have port bit_take  output  1  s_in is consumed this cycle; tx_nrzi advances.
REQ-011 SHALL have port end_tx_nrzi  output  1  the last payload bit is consumed this cycle.
REQ-012 SHALL have port bus_out  output  2  line state: J=2'b10, K=2'b01, X=2'b00.
REQ-013 SHALL have port bus_en  output  1  1 = block drives the bus (the receiver ignores the bus while high).
REQ-014 SHALL have port busy  output  1  high in every non-IDLE state.
REQ-015 SHALL have port done  output  1  one-cycle pulse on the final EOP J symbol.

Function
REQ-016 SHALL implement states IDLE, SYNC, DATA, EOP1, EOP2, EOPJ; all outputs are Moore functions of state and counter, except where noted.
REQ-017 SHALL, in IDLE, drive bus_en=0 and bus_out=X.
REQ-018 SHALL, in IDLE, latch the packet length and enter SYNC on send_hshake or send_data; when both are high, hshake wins and HSHAKE_BITS is latched.
REQ-019 SHALL ignore send_data and send_hshake in every non-IDLE state.
REQ-020 SHALL, in SYNC, drive bus_en=1 for exactly 8 cycles with symbols K,J,K,J,K,J,K,K, indexed by a 7-bit counter starting at 0.
REQ-021 SHALL assert start_tx_nrzi only in the 8th SYNC cycle (final K), then enter DATA with the counter cleared.
REQ-022 SHALL, in DATA, drive bus_en=1, bus_out=J when s_in=1, K when s_in=0, bit_take=1, and increment the counter every cycle.
REQ-023 SHALL leave DATA after exactly the latched length of cycles; end_tx_nrzi is high only in the last DATA cycle.
REQ-024 SHALL drive X in EOP1, X in EOP2 and J in EOPJ, with bus_en=1, one cycle each.
REQ-025 SHALL assert done in EOPJ and return to IDLE on the next cycle.
REQ-026 SHALL make the first SYNC K appear the cycle after the start request is sampled, giving one cycle of latency.
REQ-027 SHALL produce a total driven span of 8+N+3 cycles, where N is the latched length.
REQ-028 SHALL let abort, in any state, force IDLE on the next edge and clear the counter; done and end_tx_nrzi are not asserted.
REQ-029 SHALL accept a start in the same cycle abort is deasserted, but not in the cycle abort is high.
REQ-030 SHALL compare the counter against the latched 7-bit length, which holds its value until the next start.

Reset
REQ-031 SHALL give rst priority over abort and over all other inputs.
REQ-032 SHALL, on reset, set state=IDLE, counter=0 and latched length=DATA_BITS.
REQ-033 SHALL, on reset, set bus_en=0, bus_out=X, busy=0, done=0, bit_take=0, start_tx_nrzi=0 and end_tx_nrzi=0.
REQ-034 SHALL, on rst asserted mid-packet, release the bus in the cycle after the sampling edge.

Structure
REQ-035 SHALL place the J/K/X constants, DATA_BITS/HSHAKE_BITS defaults and the state enum in shared package usb_pkg, which rc_dpdm also uses.
REQ-036 SHALL instantiate the existing 7-bit counter for the bit/symbol counter; the length register and 2:1 mux SHALL be inline.

Verification
REQ-037 SHALL cover a handshake: send_hshake pulse, s_in=1,0,1,1,0,0,1,0 -> bus K,J,K,J,K,J,K,K, J,K,J,J,K,K,J,K, X,X,J; bus_en high 19 cycles; done on cycle 19.
REQ-038 SHALL cover a data packet: send_data, 88 bits -> bus_en high 99 cycles; bit_take high 88 cycles; end_tx_nrzi in driven cycle 96; start_tx_nrzi in cycle 8.
REQ-039 SHALL cover a simultaneous request: send_data=send_hshake=1 -> 8-bit packet, 19 driven cycles.
REQ-040 SHALL cover abort: abort at DATA bit 40 of a data packet -> bus_en=0 next cycle; no done or end_tx_nrzi; a new send_hshake then gives a clean 19-cycle packet.
REQ-041 SHALL cover reset mid-SYNC: rst at SYNC cycle 3 -> all outputs at reset values next cycle.
REQ-042 SHALL cover busy ignore plus loopback: send_data pulsed during EOP1 -> ignored; with bus_out fed to rc_dpdm (receive_data=1), got_sync fires and EOP_error stays 0.
